// File: rtl/sram_ctrl_pkg.sv
// Shared defaults and helpers for the SRAM-backed stream FIFO controller.
package sram_ctrl_pkg;

  localparam int unsigned DefBits      = 16;
  localparam int unsigned DefAddrWidth = 14;
  localparam int unsigned DefDepth     = 16384;

  // Next pointer with wrap at depth-1; depth need not be a power of two.
  function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry output queue holding RAM read returns in order.
module sram_fifo_obuf #(
  parameter int unsigned BITS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  logic [BITS-1:0] push_data,
  input  logic            pop,
  output logic [1:0]      count,
  output logic [BITS-1:0] head
);

  logic [BITS-1:0] mem_q [2];
  logic            wr_idx_q;
  logic            rd_idx_q;
  logic [1:0]      count_q;
  logic [1:0]      count_d;

  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_idx_q <= 1'b0;
      rd_idx_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_idx_q] <= push_data;
        wr_idx_q        <= ~wr_idx_q;
      end
      if (pop) begin
        rd_idx_q <= ~rd_idx_q;
      end
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_idx_q];

endmodule

// File: rtl/sram_stream_fifo_ctrl.sv
// Streaming FIFO over a 1RW+1RW RAM: writes via rw0, reads via rw1, and hides the
// one-cycle read latency behind a two-entry output queue.
module sram_stream_fifo_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned BITS       = DefBits,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DEPTH      = DefDepth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BITS-1:0]       out_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  ram_rw0_ce,
  output logic                  ram_rw0_we,
  output logic [ADDR_WIDTH-1:0] ram_rw0_addr,
  output logic [BITS-1:0]       ram_rw0_wd,
  output logic                  ram_rw1_ce,
  output logic                  ram_rw1_we,
  output logic [ADDR_WIDTH-1:0] ram_rw1_addr,
  output logic [BITS-1:0]       ram_rw1_wd,
  input  logic [BITS-1:0]       ram_rw1_rd
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam int unsigned LvlW = ADDR_WIDTH + 2;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       mem_cnt_q, mem_cnt_d;
  logic                  inflight_q;
  logic [1:0]            ob_cnt;
  logic [2:0]            occ;
  logic                  clr;
  logic                  push;
  logic                  pop;
  logic                  rd;

  assign clr       = rst || flush;
  assign in_ready  = !clr && (mem_cnt_q != CntW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign out_valid = (ob_cnt != 2'd0);
  assign pop       = out_valid && out_ready;

  // Issue a read only if its return is guaranteed a free obuf slot.
  always_comb begin
    occ = {1'b0, ob_cnt} + {2'b0, inflight_q};
    rd  = !clr && (mem_cnt_q != '0) && (occ <= 3'd1 + {2'b0, pop});
  end

  always_comb begin
    wr_ptr_d  = push ? ADDR_WIDTH'(ptr_wrap(32'(wr_ptr_q), DEPTH)) : wr_ptr_q;
    rd_ptr_d  = rd   ? ADDR_WIDTH'(ptr_wrap(32'(rd_ptr_q), DEPTH)) : rd_ptr_q;
    mem_cnt_d = mem_cnt_q + CntW'(push) - CntW'(rd);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= rd;
    end
  end

  // ram_rw1_rd is only sampled in the cycle after a read strobe.
  sram_fifo_obuf #(
    .BITS (BITS)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (inflight_q),
    .push_data (ram_rw1_rd),
    .pop       (pop),
    .count     (ob_cnt),
    .head      (out_data)
  );

  assign level = LvlW'(mem_cnt_q) + LvlW'(inflight_q) + LvlW'(ob_cnt);

  assign ram_rw0_ce   = push;
  assign ram_rw0_we   = push;
  assign ram_rw0_addr = wr_ptr_q;
  assign ram_rw0_wd   = in_data;
  assign ram_rw1_ce   = rd;
  assign ram_rw1_we   = 1'b0;
  assign ram_rw1_addr = rd_ptr_q;
  assign ram_rw1_wd   = '0;

endmodule
